// File: rtl/fetch_pc_unit_pkg.sv
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared types and constants for the WISC IF-stage PC sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

  typedef logic [15:0] pc_t;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  localparam logic [3:0] OPC_HLT = 4'hF;
  localparam pc_t        PC_INC  = 16'd2;

endpackage

`default_nettype wire

// File: rtl/fetch_pc_unit_if.sv
// ============================================================================
// Module   : fetch_pc_unit_if
// Brief    : Fetch-unit bus: imem/predictor inputs, ID resolution, IF/ID outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_pc_unit_if;

  logic [15:0] instr;
  logic        stall;
  logic        predicted_taken;
  logic [15:0] predicted_target;
  logic        was_branch;
  logic        branch_mispredicted;
  logic        actual_taken;
  logic [15:0] actual_target;

  logic [15:0] PC_curr;
  logic [15:0] PC_next;
  logic        bp_enable;
  logic [15:0] IF_ID_instr;
  logic [15:0] IF_ID_PC_curr;
  logic [15:0] IF_ID_PC_next;
  logic        IF_ID_predicted_taken;
  logic [15:0] IF_ID_predicted_target;
  logic        IF_ID_valid;
  logic        halted;
  logic [15:0] branch_cnt;
  logic [15:0] mispredict_cnt;

  // master = the fetch unit itself
  modport master (
    input  instr, stall, predicted_taken, predicted_target,
           was_branch, branch_mispredicted, actual_taken, actual_target,
    output PC_curr, PC_next, bp_enable,
           IF_ID_instr, IF_ID_PC_curr, IF_ID_PC_next,
           IF_ID_predicted_taken, IF_ID_predicted_target, IF_ID_valid,
           halted, branch_cnt, mispredict_cnt
  );

  modport slave (
    output instr, stall, predicted_taken, predicted_target,
           was_branch, branch_mispredicted, actual_taken, actual_target,
    input  PC_curr, PC_next, bp_enable,
           IF_ID_instr, IF_ID_PC_curr, IF_ID_PC_next,
           IF_ID_predicted_taken, IF_ID_predicted_target, IF_ID_valid,
           halted, branch_cnt, mispredict_cnt
  );

endinterface

`default_nettype wire

// File: rtl/fetch_pc_unit_sat_counter16.sv
// ============================================================================
// Module   : sat_counter16
// Brief    : 16-bit up-counter that sticks at 16'hFFFF instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter16 (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        inc,
  output logic [15:0]      count
);

  localparam logic [15:0] C_MAX = 16'hFFFF;

  logic [15:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (inc && (r_count != C_MAX)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/fetch_pc_unit.sv
// ============================================================================
// Module   : fetch_pc_unit
// Brief    : IF-stage PC sequencer, HLT tracking and IF/ID pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter pc_t         RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  fetch_pc_unit_if.master  bus
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  pc_t          r_pc;
  pc_t          w_pc_nxt;
  pc_t          w_pc_plus;
  pc_t          w_redirect_pc;
  logic         w_is_hlt;

  logic [15:0]  r_if_id_instr;
  pc_t          r_if_id_pc_curr;
  pc_t          r_if_id_pc_next;
  logic         r_if_id_pred_taken;
  pc_t          r_if_id_pred_target;
  logic         r_if_id_valid;

  assign w_pc_plus     = r_pc + PC_INC;
  assign w_redirect_pc = bus.actual_taken ? bus.actual_target : r_if_id_pc_next;
  assign w_is_hlt      = (bus.instr[15:12] == OPC_HLT);

  // A mispredict outranks stall and HALT: it squashes whatever was fetched.
  always_comb begin
    w_pc_nxt    = r_pc;
    w_state_nxt = r_state;
    if (bus.branch_mispredicted) begin
      w_pc_nxt    = w_redirect_pc;
      w_state_nxt = RUN;
    end else if (bus.stall) begin
      w_pc_nxt = r_pc;
    end else if (r_state == HALT) begin
      w_pc_nxt = r_pc;
    end else if (w_is_hlt) begin
      w_pc_nxt    = r_pc;
      w_state_nxt = HALT;
    end else if (bus.predicted_taken) begin
      w_pc_nxt = bus.predicted_target;
    end else begin
      w_pc_nxt = w_pc_plus;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_state <= RUN;
    end else begin
      r_pc    <= w_pc_nxt;
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_id_instr       <= NOP_INSTR;
      r_if_id_pc_curr     <= '0;
      r_if_id_pc_next     <= '0;
      r_if_id_pred_taken  <= 1'b0;
      r_if_id_pred_target <= '0;
      r_if_id_valid       <= 1'b0;
    end else if (bus.branch_mispredicted || (!bus.stall && (r_state == HALT))) begin
      r_if_id_instr       <= NOP_INSTR;
      r_if_id_pc_curr     <= '0;
      r_if_id_pc_next     <= '0;
      r_if_id_pred_taken  <= 1'b0;
      r_if_id_pred_target <= '0;
      r_if_id_valid       <= 1'b0;
    end else if (!bus.stall) begin
      // The HLT instruction itself travels down the pipe as a valid entry.
      r_if_id_instr       <= bus.instr;
      r_if_id_pc_curr     <= r_pc;
      r_if_id_pc_next     <= w_pc_plus;
      r_if_id_pred_taken  <= bus.predicted_taken;
      r_if_id_pred_target <= bus.predicted_target;
      r_if_id_valid       <= 1'b1;
    end
  end

  sat_counter16 u_branch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bus.was_branch),
    .count (bus.branch_cnt)
  );

  sat_counter16 u_mispredict_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bus.branch_mispredicted),
    .count (bus.mispredict_cnt)
  );

  assign bus.PC_curr                = r_pc;
  assign bus.PC_next                = w_pc_plus;
  assign bus.bp_enable              = ~bus.stall;
  assign bus.IF_ID_instr            = r_if_id_instr;
  assign bus.IF_ID_PC_curr          = r_if_id_pc_curr;
  assign bus.IF_ID_PC_next          = r_if_id_pc_next;
  assign bus.IF_ID_predicted_taken  = r_if_id_pred_taken;
  assign bus.IF_ID_predicted_target = r_if_id_pred_target;
  assign bus.IF_ID_valid            = r_if_id_valid;
  assign bus.halted                 = (r_state == HALT);

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
// ============================================================================
// Module   : tb_fetch_pc_unit
// Brief    : Directed, table-driven self-checking bench for fetch_pc_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_pc_unit;

  typedef struct {
    logic [15:0] instr;
    logic        stall;
    logic        pt;
    logic [15:0] ptgt;
    logic        wb;
    logic        mis;
    logic        at;
    logic [15:0] atgt;
    logic [15:0] e_pc;
    logic [15:0] e_instr;
    logic [15:0] e_ifpc;
    logic [15:0] e_ifpcn;
    logic        e_pt;
    logic [15:0] e_ptgt;
    logic        e_valid;
    logic        e_halt;
    logic [15:0] e_bc;
    logic [15:0] e_mc;
    logic        e_bpen;
  } vec_t;

  localparam int NV = 19;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  vec_t vecs [NV];

  fetch_pc_unit_if bus ();

  fetch_pc_unit #(
    .RESET_PC  (16'h0000),
    .NOP_INSTR (16'h0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] instr, input logic stall, input logic pt,
                       input logic [15:0] ptgt, input logic wb, input logic mis,
                       input logic at, input logic [15:0] atgt);
    bus.instr               = instr;
    bus.stall               = stall;
    bus.predicted_taken     = pt;
    bus.predicted_target    = ptgt;
    bus.was_branch          = wb;
    bus.branch_mispredicted = mis;
    bus.actual_taken        = at;
    bus.actual_target       = atgt;
  endtask

  task automatic chk_vec(input int i, input vec_t v);
    chk("PC_curr",        i, bus.PC_curr, v.e_pc);
    chk("PC_next",        i, bus.PC_next, v.e_pc + 16'd2);
    chk("IF_ID_instr",    i, bus.IF_ID_instr, v.e_instr);
    chk("IF_ID_PC_curr",  i, bus.IF_ID_PC_curr, v.e_ifpc);
    chk("IF_ID_PC_next",  i, bus.IF_ID_PC_next, v.e_ifpcn);
    chk("IF_ID_pred_tk",  i, {15'd0, bus.IF_ID_predicted_taken}, {15'd0, v.e_pt});
    chk("IF_ID_pred_tgt", i, bus.IF_ID_predicted_target, v.e_ptgt);
    chk("IF_ID_valid",    i, {15'd0, bus.IF_ID_valid}, {15'd0, v.e_valid});
    chk("halted",         i, {15'd0, bus.halted}, {15'd0, v.e_halt});
    chk("branch_cnt",     i, bus.branch_cnt, v.e_bc);
    chk("mispredict_cnt", i, bus.mispredict_cnt, v.e_mc);
    chk("bp_enable",      i, {15'd0, bus.bp_enable}, {15'd0, v.e_bpen});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    //        instr     st    pt    ptgt      wb    mis   at    atgt        pc        ifinstr   ifpc      ifpcn     ifpt  ifptgt    val   halt  bc        mc        bpen
    vecs[0]  = '{16'h1234,1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000, 16'h0002,16'h1234,16'h0000,16'h0002,1'b0,16'h0000,1'b1,1'b0,16'd0,16'd0,1'b1};
    vecs[1]  = '{16'h1234,1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000, 16'h0004,16'h1234,16'h0002,16'h0004,1'b0,16'h0000,1'b1,1'b0,16'd0,16'd0,1'b1};
    vecs[2]  = '{16'h1234,1'b0,1'b1,16'h0040,1'b0,1'b0,1'b0,16'h0000, 16'h0040,16'h1234,16'h0004,16'h0006,1'b1,16'h0040,1'b1,1'b0,16'd0,16'd0,1'b1};
    // mispredict not-taken under stall: redirect to IF_ID_PC_next
    vecs[3]  = '{16'h1234,1'b1,1'b0,16'h0000,1'b1,1'b1,1'b0,16'h0000, 16'h0006,16'h0000,16'h0000,16'h0000,1'b0,16'h0000,1'b0,1'b0,16'd1,16'd1,1'b0};
    vecs[4]  = '{16'h1234,1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000, 16'h0008,16'h1234,16'h0006,16'h0008,1'b0,16'h0000,1'b1,1'b0,16'd1,16'd1,1'b1};
    vecs[5]  = '{16'h1234,1'b0,1'b0,16'h0000,1'b1,1'b1,1'b1,16'h0100, 16'h0100,16'h0000,16'h0000,16'h0000,1'b0,16'h0000,1'b0,1'b0,16'd2,16'd2,1'b1};
    vecs[6]  = '{16'h1234,1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000, 16'h0102,16'h1234,16'h0100,16'h0102,1'b0,16'h0000,1'b1,1'b0,16'd2,16'd2,1'b1};
    vecs[7]  = '{16'h1234,1'b1,1'b0,16'h0000,1'b1,1'b0,1'b0,16'h0000, 16'h0102,16'h1234,16'h0100,16'h0102,1'b0,16'h0000,1'b1,1'b0,16'd3,16'd2,1'b0};
    vecs[8]  = '{16'h1234,1'b1,1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000, 16'h0102,16'h1234,16'h0100,16'h0102,1'b0,16'h0000,1'b1,1'b0,16'd3,16'd2,1'b0};
    // HLT fetch: latched valid, PC holds, then NOPs while halted
    vecs[9]  = '{16'hF000,1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000, 16'h0102,16'hF000,16'h0102,16'h0104,1'b0,16'h0000,1'b1,1'b1,16'd3,16'd2,1'b1};
    vecs[10] = '{16'hF000,1'b0,1'b1,16'h0200,1'b0,1'b0,1'b0,16'h0000, 16'h0102,16'h0000,16'h0000,16'h0000,1'b0,16'h0000,1'b0,1'b1,16'd3,16'd2,1'b1};
    vecs[11] = '{16'h5555,1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000, 16'h0102,16'h0000,16'h0000,16'h0000,1'b0,16'h0000,1'b0,1'b1,16'd3,16'd2,1'b1};
    vecs[12] = '{16'h5555,1'b0,1'b0,16'h0000,1'b1,1'b1,1'b1,16'h0030, 16'h0030,16'h0000,16'h0000,16'h0000,1'b0,16'h0000,1'b0,1'b0,16'd4,16'd3,1'b1};
    // HLT and mispredict together: mispredict wins, stays RUN
    vecs[13] = '{16'hF000,1'b0,1'b0,16'h0000,1'b1,1'b1,1'b1,16'h0050, 16'h0050,16'h0000,16'h0000,16'h0000,1'b0,16'h0000,1'b0,1'b0,16'd5,16'd4,1'b1};
    vecs[14] = '{16'h1234,1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000, 16'h0052,16'h1234,16'h0050,16'h0052,1'b0,16'h0000,1'b1,1'b0,16'd5,16'd4,1'b1};
    vecs[15] = '{16'h1234,1'b0,1'b0,16'h0000,1'b0,1'b1,1'b1,16'hFFFE, 16'hFFFE,16'h0000,16'h0000,16'h0000,1'b0,16'h0000,1'b0,1'b0,16'd5,16'd5,1'b1};
    vecs[16] = '{16'h1234,1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000, 16'h0000,16'h1234,16'hFFFE,16'h0000,1'b0,16'h0000,1'b1,1'b0,16'd5,16'd5,1'b1};
    vecs[17] = '{16'h1234,1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000, 16'h0002,16'h1234,16'h0000,16'h0002,1'b0,16'h0000,1'b1,1'b0,16'd5,16'd5,1'b1};
    vecs[18] = '{16'h1234,1'b1,1'b1,16'h0040,1'b0,1'b0,1'b0,16'h0000, 16'h0002,16'h1234,16'h0000,16'h0002,1'b0,16'h0000,1'b1,1'b0,16'd5,16'd5,1'b0};

    rst_n = 1'b0;
    drive(16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset PC_curr",     -1, bus.PC_curr, 16'h0000);
    chk("reset IF_ID_valid", -1, {15'd0, bus.IF_ID_valid}, 16'h0000);
    chk("reset IF_ID_instr", -1, bus.IF_ID_instr, 16'h0000);
    chk("reset halted",      -1, {15'd0, bus.halted}, 16'h0000);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].instr, vecs[i].stall, vecs[i].pt, vecs[i].ptgt,
            vecs[i].wb, vecs[i].mis, vecs[i].at, vecs[i].atgt);
      @(posedge clk);
      #1;
      chk_vec(i, vecs[i]);
    end

    // Asynchronous reset between clock edges
    drive(16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    chk("pre-reset PC_curr", 100, bus.PC_curr, 16'h0008);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async PC_curr",        101, bus.PC_curr, 16'h0000);
    chk("async IF_ID_valid",    101, {15'd0, bus.IF_ID_valid}, 16'h0000);
    chk("async IF_ID_instr",    101, bus.IF_ID_instr, 16'h0000);
    chk("async branch_cnt",     101, bus.branch_cnt, 16'h0000);
    chk("async mispredict_cnt", 101, bus.mispredict_cnt, 16'h0000);
    chk("async halted",         101, {15'd0, bus.halted}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Saturation of both counters
    drive(16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    force dut.u_mispredict_cnt.r_count = 16'hFFFF;
    force dut.u_branch_cnt.r_count     = 16'hFFFE;
    #1;
    release dut.u_mispredict_cnt.r_count;
    release dut.u_branch_cnt.r_count;
    #1;
    chk("preload mispredict_cnt", 200, bus.mispredict_cnt, 16'hFFFF);
    drive(16'h1234, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000);
    @(posedge clk);
    #1;
    chk("sat mispredict_cnt", 201, bus.mispredict_cnt, 16'hFFFF);
    chk("inc branch_cnt",     201, bus.branch_cnt, 16'hFFFF);
    @(posedge clk);
    #1;
    chk("sat mispredict_cnt", 202, bus.mispredict_cnt, 16'hFFFF);
    chk("sat branch_cnt",     202, bus.branch_cnt, 16'hFFFF);
    drive(16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- IF-stage PC sequencer and IF/ID pipeline register for the 16-bit WISC pipeline.
- Owns PC_curr, which drives instruction memory and the DynamicBranchPredictor index. It consumes the predictor's predicted_taken/predicted_target.
- Applies ID-stage mispredict redirects and latches fetched instruction plus prediction metadata into IF/ID.
- Tracks HLT with a two-state FSM and keeps saturating branch/mispredict counters.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0000, instruction injected into IF/ID on flush or halt.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  16  instruction memory read data for PC_curr (combinational read).
- stall  in  1  hazard-unit stall; holds PC and IF/ID.
- predicted_taken  in  1  from branch predictor, for PC_curr.
- predicted_target  in  16  from branch predictor, for PC_curr.
- was_branch  in  1  ID-stage branch resolved this cycle (single-cycle pulse per branch).
- branch_mispredicted  in  1  ID-stage prediction was wrong.
- actual_taken  in  1  ID-stage resolved direction.
- actual_target  in  16  ID-stage resolved target.
- PC_curr  out  16  current fetch PC (register).
- PC_next  out  16  PC_curr+2 (combinational).
- bp_enable  out  1  predictor update enable = ~stall.
- IF_ID_instr  out  16  latched instruction.
- IF_ID_PC_curr  out  16  latched PC_curr.
- IF_ID_PC_next  out  16  latched PC_next.
- IF_ID_predicted_taken  out  1  latched prediction.
- IF_ID_predicted_target  out  16  latched target.
- IF_ID_valid  out  1  0 for injected NOP.
- halted  out  1  FSM in HALT.
- branch_cnt  out  16  resolved branches, saturating.
- mispredict_cnt  out  16  mispredicts, saturating.

Behaviour:
- Reset (async, rst_n=0):
  - PC_curr=RESET_PC.
  - IF_ID_instr=NOP_INSTR; all other IF_ID_* = 0; IF_ID_valid=0.
  - State RUN; counters 0.
  - Reset mid-operation discards everything immediately, without waiting for a clock edge.
- Arithmetic: PC_next=PC_curr+16'd2, mod 2^16, so 0xFFFE wraps to 0x0000.
- Redirect PC: actual_taken ? actual_target : IF_ID_PC_next.
- Next-PC priority, evaluated per posedge:
  1. branch_mispredicted -> redirect PC. Wins over stall and over HALT.
  2. stall -> hold.
  3. State HALT -> hold.
  4. RUN and instr[15:12]==4'hF (HLT) -> hold PC; state -> HALT.
  5. predicted_taken -> predicted_target.
  6. Otherwise PC_next.
- IF/ID register update, per posedge:
  - branch_mispredicted: flush. instr=NOP_INSTR, valid=0, predicted_taken=0, predicted_target=0; PC fields = 0.
  - Else stall: hold all fields.
  - Else HALT: inject NOP (valid=0), same as flush.
  - Else: load instr, PC_curr, PC_next, predicted_taken, predicted_target; valid=1. The HLT instruction itself is latched valid.
- FSM:
  - RUN -> HALT on unstalled, unflushed HLT fetch.
  - HALT -> RUN only on branch_mispredicted, which squashes a speculatively fetched HLT; PC takes the redirect PC.
  - HLT and mispredict in the same cycle: mispredict wins; state stays RUN.
  - halted = (state==HALT), registered.
- Counters:
  - branch_cnt +1 on was_branch.
  - mispredict_cnt +1 on branch_mispredicted.
  - Both count independent of stall and state; saturate at 16'hFFFF (no wrap).
- bp_enable = ~stall (combinational).

Decomposition:
- Package fetch_pkg:
  - pc_t (logic [15:0]).
  - fetch_state_t enum {RUN, HALT}.
  - OPC_HLT=4'hF.
  - PC_INC=16'd2.
- Sub-module sat_counter16 (inc, count, async active-low reset), instantiated twice for the counters.

Test Plan:
- Reset: run to PC 0x0008, drop rst_n between edges -> PC_curr=0x0000 immediately, IF_ID_valid=0, IF_ID_instr=0x0000, counters=0, halted=0.
- Sequential + wrap: instr=0x1234, no predictions, 3 edges -> PC 0x0002/0x0004/0x0006; IF_ID_PC_curr lags one cycle, IF_ID_PC_next=IF_ID_PC_curr+2. Preload PC 0xFFFE -> next 0x0000.
- Predicted taken: at PC 0x0004, predicted_taken=1, predicted_target=0x0040 -> PC 0x0040; IF_ID_predicted_taken=1, IF_ID_predicted_target=0x0040.
- Mispredict, not taken: IF_ID_PC_next=0x0006, branch_mispredicted=1, actual_taken=0, was_branch=1, stall=1 -> PC 0x0006, IF_ID flushed (valid=0), branch_cnt=1, mispredict_cnt=1.
- Mispredict, taken: actual_taken=1, actual_target=0x0100 -> PC 0x0100.
- Stall: stall=1 for 2 cycles at PC 0x0010 -> PC_curr and all IF_ID_* unchanged; bp_enable=0.
- Halt: instr=0xF000 at PC 0x0020 -> IF_ID gets 0xF000 valid, PC holds 0x0020, halted=1, following IF_ID entries are NOP. Then mispredict with actual_target=0x0030 -> halted=0, PC 0x0030.
- Counter saturation: force mispredict_cnt to 0xFFFF, pulse branch_mispredicted -> stays 0xFFFF.
